sampletest_arbiter: RTL and testbench
=====================================

# sampletest_arbiter

Shares one `sampletest` datapath between two sample-iterator lanes. Each cycle it grants at most one lane's (triangle, color, sample) triple into the tester, round-robin among eligible lanes, and tracks the granted lane ID down a tag pipeline matched to the tester latency. Results are steered back to the owning lane. It also bounds each lane's outstanding samples with a credit counter and provides an enable/drain state machine for clean hand-off between triangles.

## Interface
Parameters:
- `SIGFIG`, 24, bits in color and position
- `VERTS`, 3, vertices per triangle
- `AXIS`, 3, axes per vertex (x,y,z)
- `COLORS`, 3, color channels
- `PIPE_DEPTH`, 2, R16→R18 latency of the shared `sampletest` (≥1)
- `CREDITS`, 4, per-lane downstream result slots (≥1); counter width `$clog2(CREDITS+1)`

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-low
- `en_R16H`  in  1  run enable
- `req_valid_R16H`  in  [1:0]  lane i presents a sample
- `req_tri_R16S`  in  signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  per-lane triangle
- `req_color_R16U`  in  [1:0][COLORS-1:0][SIGFIG-1:0]  per-lane color
- `req_sample_R16S`  in  signed [1:0][1:0][SIGFIG-1:0]  per-lane sample location
- `req_ready_R16H`  out  [1:0]  lane i granted this cycle
- `st_tri_R16S`, `st_color_R16U`, `st_sample_R16S`  out  same widths as one lane  muxed to tester
- `st_validSamp_R16H`  out  1  drives tester `validSamp_R16H`
- `st_hit_valid_R18H`  in  1  tester hit flag
- `rsp_valid_R18H`  out  [1:0]  lane i's sample result emerges (hit or miss)
- `rsp_hit_R18H`  out  [1:0]  lane i's sample hit
- `rsp_pop_R18H`  in  [1:0]  downstream freed one slot of lane i
- `idle_R16H`  out  1  FSM in IDLE

## Operation
- FSM states:
  - IDLE → RUN when `en_R16H`=1.
  - RUN → DRAIN when `en_R16H`=0.
  - DRAIN → IDLE when the tag pipe is empty (all `pipe_vld` = 0) and `en_R16H`=0.
  - DRAIN → RUN when `en_R16H`=1, regardless of pipe state.
- Grants occur only in RUN. `idle_R16H` = (state==IDLE).
- Lane i is eligible when `req_valid[i]` && `credit[i]` > 0.
  - One eligible lane: it is granted.
  - Both eligible: grant the lane ≠ `last`.
  - `last` updates to the granted lane on every grant and holds otherwise.
- `req_ready_R16H` is the one-hot grant, combinational from the current inputs and state. At most one bit is set.
- `st_*` buses carry the granted lane's fields and lane 0's fields when there is no grant. `st_validSamp_R16H` = |grant.
- Tag pipe: shift register of PIPE_DEPTH stages, each holding {vld, id}, advancing every cycle. Stage 0 loads {|grant, granted id}.
- Final stage {v, id}:
  - `rsp_valid[id]` = v
  - `rsp_hit[id]` = v && `st_hit_valid_R18H`
  - the other lane's bits are 0
- Credits:
  - `credit[i]` decrements on grant to i and increments on `rsp_pop[i]`. Both in one cycle: unchanged.
  - A pop with `credit[i]`==CREDITS is ignored, and a simulation assertion fires.
  - Credits are returned only by pop, never by response emission.
- `en_R16H` deassert mid-pipe: in-flight tags keep shifting and responses still emerge.

## Timing
- Reset (`rst`=0 at posedge) sets:
  - state=IDLE
  - `last`=1, so lane 0 wins the first tie
  - all `pipe_vld`=0
  - `credit`=CREDITS
- Resulting output values: `req_ready`=0, `st_validSamp`=0, `rsp_valid`=0, `rsp_hit`=0, `idle`=1.
- Reset asserted mid-operation discards in-flight tags; their responses never appear.
- A grant at posedge-cycle t produces `rsp_valid` at cycle t+PIPE_DEPTH.
- Throughput: one grant per cycle in RUN while credits last.
- First grant possible in the cycle after `en_R16H` is sampled high in IDLE.
- DRAIN→IDLE takes max(1, cycles until last tag exits).
- A credit freed by a pop at cycle t is usable for a grant at t+1.

## Test plan
- Reset then `en`=1, both lanes valid continuously, pops immediate, PIPE_DEPTH=2 → grants alternate 0,1,0,1…; each `rsp_valid[id]` appears 2 cycles after its grant with a matching id.
- Lane 0 alone valid, no pops, CREDITS=4 → exactly 4 grants in cycles 1–4, then `req_ready[0]`=0. One pop → a single further grant in the next cycle.
- Tester returns hit=1 for even grants and hit=0 for odd → `rsp_hit` is set only for even-grant responses, and `rsp_valid` for all.
- `en` dropped one cycle after a grant → no new grants. `idle`=1 once that response exits (2 cycles later). Re-raising `en` in DRAIN returns to RUN with no IDLE visit.
- Simultaneous grant and pop on lane 1 with credit=1 → credit stays 1 and lane 1 is granted again next cycle.
- `rst`=0 with 2 tags in flight → no `rsp_valid` afterward, credits=4, `idle`=1.

Source files
------------

// File: rtl/sampletest_arbiter.sv
// sampletest_arbiter: round-robin share of one sampletest datapath between two lanes,
// with a latency-matched tag pipe, per-lane credits and an enable/drain FSM.
module sampletest_arbiter #(
    parameter int SIGFIG     = 24,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int PIPE_DEPTH = 2,
    parameter int CREDITS    = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                en_R16H,
    input  logic [1:0]                                          req_valid_R16H,
    input  logic signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  req_tri_R16S,
    input  logic [1:0][COLORS-1:0][SIGFIG-1:0]                  req_color_R16U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]                  req_sample_R16S,
    output logic [1:0]                                          req_ready_R16H,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]       st_tri_R16S,
    output logic [COLORS-1:0][SIGFIG-1:0]                       st_color_R16U,
    output logic signed [1:0][SIGFIG-1:0]                       st_sample_R16S,
    output logic                                                st_validSamp_R16H,
    input  logic                                                st_hit_valid_R18H,
    output logic [1:0]                                          rsp_valid_R18H,
    output logic [1:0]                                          rsp_hit_R18H,
    input  logic [1:0]                                          rsp_pop_R18H,
    output logic                                                idle_R16H
);
    localparam int CW = $clog2(CREDITS + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, nxt;
    logic run, last;
    logic [1:0] elig, grant, pop_ok;
    logic [CW-1:0] credit [2];
    logic [PIPE_DEPTH-1:0] vld, id;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = (state == IDLE) ? (en_R16H ? RUN : IDLE) :
              (state == RUN)  ? (en_R16H ? RUN : DRAIN) :
              (en_R16H ? RUN : (|vld ? DRAIN : IDLE));
    end

    always_comb begin
        run       = (state == RUN);
        idle_R16H = (state == IDLE);
    end

    // On a tie the lane that did not win last time gets the grant.
    always_comb begin
        elig  = req_valid_R16H & {credit[1] != '0, credit[0] != '0};
        grant = !run ? 2'b00 : (&elig) ? (last ? 2'b01 : 2'b10) : elig;
    end

    assign req_ready_R16H    = grant;
    assign st_validSamp_R16H = |grant;
    assign st_tri_R16S       = req_tri_R16S[grant[1]];
    assign st_color_R16U     = req_color_R16U[grant[1]];
    assign st_sample_R16S    = req_sample_R16S[grant[1]];

    always_ff @(posedge clk) begin
        if (!rst) last <= 1'b1;
        else if (|grant) last <= grant[1];
    end

    always_ff @(posedge clk) begin
        for (int s = PIPE_DEPTH - 1; s > 0; s--) begin
            vld[s] <= vld[s-1];
            id[s]  <= id[s-1];
        end
        vld[0] <= |grant;
        id[0]  <= grant[1];
        if (!rst) vld <= '0;
    end

    assign rsp_valid_R18H = vld[PIPE_DEPTH-1] ? (id[PIPE_DEPTH-1] ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_hit_R18H   = rsp_valid_R18H & {2{st_hit_valid_R18H}};

    // A pop into a full counter has no slot to return, so it is dropped.
    assign pop_ok = rsp_pop_R18H & {credit[1] != CW'(CREDITS), credit[0] != CW'(CREDITS)};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) credit[i] <= CW'(CREDITS);
            else credit[i] <= credit[i] - CW'(grant[i]) + CW'(pop_ok[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (rst && rsp_pop_R18H[i])
                assert (credit[i] != CW'(CREDITS)) else $error("credit overflow on lane %0d", i);
    end
endmodule

// File: tb/tb_sampletest_arbiter.sv
// tb_sampletest_arbiter: directed phases with random payloads checked against
// a queue-based reference model of grants, credits and response timing.
module tb_sampletest_arbiter;
    localparam int SIGFIG = 24, VERTS = 3, AXIS = 3, COLORS = 3, D = 2, CR = 4;

    logic clk = 1'b0;
    logic rst, en;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_hit, rsp_pop;
    logic signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri;
    logic [1:0][COLORS-1:0][SIGFIG-1:0] req_color;
    logic signed [1:0][1:0][SIGFIG-1:0] req_sample;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] st_tri;
    logic [COLORS-1:0][SIGFIG-1:0] st_color;
    logic signed [1:0][SIGFIG-1:0] st_sample;
    logic st_valid, hit, idle;

    sampletest_arbiter #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                         .PIPE_DEPTH(D), .CREDITS(CR)) dut (
        .clk(clk), .rst(rst), .en_R16H(en), .req_valid_R16H(req_valid),
        .req_tri_R16S(req_tri), .req_color_R16U(req_color), .req_sample_R16S(req_sample),
        .req_ready_R16H(req_ready), .st_tri_R16S(st_tri), .st_color_R16U(st_color),
        .st_sample_R16S(st_sample), .st_validSamp_R16H(st_valid), .st_hit_valid_R18H(hit),
        .rsp_valid_R18H(rsp_valid), .rsp_hit_R18H(rsp_hit), .rsp_pop_R18H(rsp_pop),
        .idle_R16H(idle)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int lane;} tag_t;
    tag_t q[$];
    int mode = 0, m_last = 1, cyc_n = 0;
    int cr [2] = '{CR, CR};
    int vectors = 0, miscompares = 0;

    // One clock of stimulus: pm 0 = no pops, 1 = pop each lane as its response
    // emerges, 2 = random pops, 3 = pop the lanes in pmask (all gated to never overfill).
    task automatic cyc(input logic r, input logic e, input logic [1:0] v, input int pm,
                       input logic [1:0] pmask);
        int g, rl, b;
        logic empty;
        logic [1:0] pops, x_ready, x_rv, x_rh;
        while (q.size() > 0 && q[0].due < cyc_n) void'(q.pop_front());
        empty = (q.size() == 0);
        rl = (q.size() > 0 && q[0].due == cyc_n) ? q[0].lane : -1;
        rst = r; en = e; req_valid = v; hit = 1'($urandom);
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < VERTS; a++)
                for (int c = 0; c < AXIS; c++) req_tri[l][a][c] = SIGFIG'($urandom);
            for (int c = 0; c < COLORS; c++) req_color[l][c] = SIGFIG'($urandom);
            for (int c = 0; c < 2; c++) req_sample[l][c] = SIGFIG'($urandom);
        end
        for (int i = 0; i < 2; i++)
            pops[i] = (cr[i] < CR) && (pm == 1 ? rl == i : pm == 2 ? $urandom_range(0, 1) == 1 :
                                       pm == 3 ? pmask[i] : 1'b0);
        rsp_pop = pops;
        g = -1;
        if (mode == 1) begin
            if (v[0] && cr[0] > 0 && v[1] && cr[1] > 0) g = 1 - m_last;
            else if (v[0] && cr[0] > 0) g = 0;
            else if (v[1] && cr[1] > 0) g = 1;
        end
        x_ready = (g < 0) ? 2'b00 : 2'b01 << g;
        x_rv = (rl < 0) ? 2'b00 : 2'b01 << rl;
        x_rh = hit ? x_rv : 2'b00;
        @(negedge clk);
        vectors += 9;
        assert (req_ready === x_ready) else begin miscompares++; $error("FAIL ready c%0d: got %b expected %b", cyc_n, req_ready, x_ready); end
        assert (st_valid === (g >= 0)) else begin miscompares++; $error("FAIL st_valid c%0d: got %b expected %b", cyc_n, st_valid, g >= 0); end
        assert (st_tri === req_tri[g == 1]) else begin miscompares++; $error("FAIL st_tri c%0d: got %h expected %h", cyc_n, st_tri, req_tri[g == 1]); end
        assert (st_color === req_color[g == 1]) else begin miscompares++; $error("FAIL st_color c%0d: got %h expected %h", cyc_n, st_color, req_color[g == 1]); end
        assert (st_sample === req_sample[g == 1]) else begin miscompares++; $error("FAIL st_sample c%0d: got %h expected %h", cyc_n, st_sample, req_sample[g == 1]); end
        assert (rsp_valid === x_rv) else begin miscompares++; $error("FAIL rsp_valid c%0d: got %b expected %b", cyc_n, rsp_valid, x_rv); end
        assert (rsp_hit === x_rh) else begin miscompares++; $error("FAIL rsp_hit c%0d: got %b expected %b", cyc_n, rsp_hit, x_rh); end
        assert (idle === (mode == 0)) else begin miscompares++; $error("FAIL idle c%0d: got %b expected %b", cyc_n, idle, mode == 0); end
        assert (!$isunknown({req_ready, rsp_valid, idle})) else begin miscompares++; $error("FAIL xprop c%0d: got %b expected no X", cyc_n, {req_ready, rsp_valid, idle}); end
        @(posedge clk);
        if (!r) begin
            mode = 0; m_last = 1; cr = '{CR, CR}; q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                b = cr[i];
                cr[i] = b - int'(g == i) + int'(pops[i] && b < CR);
            end
            if (g >= 0) begin
                q.push_back('{cyc_n + D, g});
                m_last = g;
            end
            mode = (mode == 0) ? (e ? 1 : 0) : (mode == 1) ? (e ? 1 : 2) : (e ? 1 : (empty ? 0 : 2));
        end
        cyc_n++;
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; req_valid = 2'b00; rsp_pop = 2'b00; hit = 1'b0;
        req_tri = '0; req_color = '0; req_sample = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 0, 2'b00, 0, 2'b00);
        repeat (12) cyc(1, 1, 2'b11, 1, 2'b00);
        repeat (3) cyc(1, 1, 2'b00, 1, 2'b00);
        repeat (6) cyc(1, 1, 2'b01, 0, 2'b00);
        cyc(1, 1, 2'b01, 3, 2'b01);
        repeat (2) cyc(1, 1, 2'b01, 0, 2'b00);
        repeat (5) cyc(1, 1, 2'b00, 3, 2'b01);
        repeat (3) cyc(1, 1, 2'b10, 0, 2'b00);
        cyc(1, 1, 2'b10, 3, 2'b10);
        cyc(1, 1, 2'b10, 0, 2'b00);
        repeat (5) cyc(1, 1, 2'b00, 3, 2'b10);
        cyc(1, 1, 2'b11, 1, 2'b00);
        cyc(1, 0, 2'b11, 1, 2'b00);
        cyc(1, 0, 2'b11, 1, 2'b00);
        cyc(1, 1, 2'b11, 1, 2'b00);
        repeat (4) cyc(1, 0, 2'b11, 1, 2'b00);
        repeat (3) cyc(1, 1, 2'b11, 1, 2'b00);
        cyc(1, 1, 2'b11, 1, 2'b00);
        cyc(0, 1, 2'b11, 1, 2'b00);
        repeat (4) cyc(1, 0, 2'b00, 0, 2'b00);
        repeat (300) cyc($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0, 2'($urandom), 2, 2'b00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
